mem_dma_copy: RTL and testbench

//  Bus initiator for the 16-bit, byte-addressed, little-endian main memory port.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_dma_copy.sv | 119 +++++++++++
 tb/tb_mem_dma_copy.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared memory-port constants and DMA state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 16;
   localparam int WORD_BYTES = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } dma_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_dma_copy.sv
// ============================================================================
// Module : mem_dma_copy
// Brief  : Word-by-word memory copy initiator. MEM_DMA_CHECKSUM_EN adds a
//          running sum of the copied words on the checksum port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_dma_copy
   import mem_pkg::*;
#(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write_enable,
   input  logic [DATA_W-1:0] mem_data_out
);

   localparam logic [ADDR_W-1:0] c_step = ADDR_W'(WORD_BYTES);
   localparam logic [LEN_W-1:0]  c_one  = LEN_W'(1);

   dma_state_t        r_state;
   logic [ADDR_W-1:0] r_src_ptr;
   logic [ADDR_W-1:0] r_dst_ptr;
   logic [LEN_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_buf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_src_ptr <= '0;
         r_dst_ptr <= '0;
         r_cnt     <= '0;
         r_buf     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_src_ptr <= src_addr;
                  r_dst_ptr <= dst_addr;
                  r_cnt     <= len;
                  r_state   <= (len == '0) ? DONE : READ;
               end
            end
            READ: begin
               if (mem_gnt) begin
                  r_buf     <= mem_data_out;
                  r_src_ptr <= r_src_ptr + c_step;
                  r_state   <= WRITE;
               end
            end
            WRITE: begin
               if (mem_gnt) begin
                  r_dst_ptr <= r_dst_ptr + c_step;
                  r_cnt     <= r_cnt - c_one;
                  r_state   <= (r_cnt == c_one) ? DONE : READ;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef MEM_DMA_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_checksum <= '0;
      end else if (r_state == IDLE && start) begin
         r_checksum <= '0;
      end else if (r_state == WRITE && mem_gnt) begin
         r_checksum <= r_checksum + r_buf;
      end
   end

   assign checksum = r_checksum;
`else
   assign checksum = '0;
`endif

   assign busy    = (r_state == READ) || (r_state == WRITE);
   assign done    = (r_state == DONE);
   assign mem_req = busy;

   always_comb begin
      mem_address = '0;
      mem_data_in = '0;
      case (r_state)
         READ:  mem_address = r_src_ptr;
         WRITE: begin
            mem_address = r_dst_ptr;
            mem_data_in = r_buf;
         end
         default: ;
      endcase
   end

   // Reset suppresses the strobe so an in-flight word is never written as reset lands.
   assign mem_write_enable = (r_state == WRITE) && mem_gnt && !rst;

endmodule

`default_nettype wire

// File: tb/tb_mem_dma_copy.sv
// ============================================================================
// Module : tb_mem_dma_copy
// Brief  : Directed self-checking bench for mem_dma_copy with a byte memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_dma_copy;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] src_addr = '0;
   logic [15:0] dst_addr = '0;
   logic [15:0] len = '0;
   logic        busy;
   logic        done;
   logic [15:0] checksum;
   logic        mem_req;
   logic        mem_gnt = 1'b1;
   logic [15:0] mem_address;
   logic [15:0] mem_data_in;
   logic        mem_write_enable;
   logic [15:0] mem_data_out;

   logic [7:0]  mem [0:65535];
   logic [15:0] addr_log [0:255];

   int n_cmp = 0;
   int n_fail = 0;
   int done_cyc, we_bad, we_cnt, busy_cnt;

   mem_dma_copy dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .src_addr         (src_addr),
      .dst_addr         (dst_addr),
      .len              (len),
      .busy             (busy),
      .done             (done),
      .checksum         (checksum),
      .mem_req          (mem_req),
      .mem_gnt          (mem_gnt),
      .mem_address      (mem_address),
      .mem_data_in      (mem_data_in),
      .mem_write_enable (mem_write_enable),
      .mem_data_out     (mem_data_out)
   );

   always #5 clk = ~clk;

   // Little-endian byte memory, combinational read, write on rising edge.
   logic [15:0] w_addr_hi;
   assign w_addr_hi    = mem_address + 16'd1;
   assign mem_data_out = {mem[w_addr_hi], mem[mem_address]};

   always @(posedge clk) begin
      if (mem_write_enable) begin
         mem[mem_address] = mem_data_in[7:0];
         mem[w_addr_hi]   = mem_data_in[15:8];
      end
   end

   task automatic wr(input logic [15:0] a, input logic [15:0] w);
      logic [15:0] a1;
      a1 = a + 16'd1;
      mem[a]  = w[7:0];
      mem[a1] = w[15:8];
   endtask

   function automatic logic [15:0] rd(input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return {mem[a1], mem[a]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic gnt_for(input int c, input int mode);
      logic [3:0] pat;
      pat = 4'b1001;
      if (mode == 0) return 1'b1;
      return pat[3 - ((c - 1) % 4)];
   endfunction

   // Launch a copy (accepted at edge 0), then observe cycles 1.. until done.
   task automatic run_copy(input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input int mode);
      src_addr = s;
      dst_addr = d;
      len      = l;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      done_cyc = -1;
      we_bad   = 0;
      we_cnt   = 0;
      busy_cnt = 0;
      for (int c = 1; c <= 200; c++) begin
         mem_gnt = gnt_for(c, mode);
         #1;
         addr_log[c[7:0]] = mem_address;
         if (busy) busy_cnt++;
         if (mem_write_enable) we_cnt++;
         if (!mem_gnt && mem_write_enable) we_bad++;
         if (done) begin
            done_cyc = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      mem_gnt = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_req",   {31'd0, mem_req}, 32'd0);
      check("rst_we",    {31'd0, mem_write_enable}, 32'd0);
      check("rst_addr",  {16'd0, mem_address}, 32'd0);
      check("rst_wdata", {16'd0, mem_data_in}, 32'd0);
      check("rst_csum",  {16'd0, checksum}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic three-word copy
      wr(16'h0100, 16'h2211);
      wr(16'h0102, 16'h4433);
      wr(16'h0104, 16'h6655);
      run_copy(16'h0100, 16'h0200, 16'd3, 0);
      check("t1_done_cyc", done_cyc, 32'd7);
      check("t1_busy_cnt", busy_cnt, 32'd6);
      check("t1_w0", {16'd0, rd(16'h0200)}, 32'h2211);
      check("t1_w1", {16'd0, rd(16'h0202)}, 32'h4433);
      check("t1_w2", {16'd0, rd(16'h0204)}, 32'h6655);
`ifdef MEM_DMA_CHECKSUM_EN
      check("t1_csum", {16'd0, checksum}, 32'h0000CC99);
`else
      check("t1_csum", {16'd0, checksum}, 32'd0);
`endif

      // Zero-length request
      run_copy(16'h0100, 16'h0600, 16'd0, 0);
      check("t2_done_cyc", done_cyc, 32'd1);
      check("t2_we_cnt",   we_cnt,   32'd0);
      check("t2_busy_cnt", busy_cnt, 32'd0);

      // Source pointer wraps past the top of memory
      wr(16'hFFFE, 16'h1234);
      wr(16'h0000, 16'h5678);
      run_copy(16'hFFFE, 16'h1000, 16'd2, 0);
      check("t3_done_cyc", done_cyc, 32'd5);
      check("t3_rd0", {16'd0, addr_log[1]}, 32'hFFFE);
      check("t3_wr0", {16'd0, addr_log[2]}, 32'h1000);
      check("t3_rd1", {16'd0, addr_log[3]}, 32'h0000);
      check("t3_wr1", {16'd0, addr_log[4]}, 32'h1002);
      check("t3_w0", {16'd0, rd(16'h1000)}, 32'h1234);
      check("t3_w1", {16'd0, rd(16'h1002)}, 32'h5678);

      // Grant stalls: four stalled cycles push done from 5 to 9
      wr(16'h0400, 16'hBEEF);
      wr(16'h0402, 16'hCAFE);
      run_copy(16'h0400, 16'h0480, 16'd2, 1);
      check("t4_done_cyc", done_cyc, 32'd9);
      check("t4_we_bad",   we_bad,   32'd0);
      check("t4_we_cnt",   we_cnt,   32'd2);
      check("t4_w0", {16'd0, rd(16'h0480)}, 32'hBEEF);
      check("t4_w1", {16'd0, rd(16'h0482)}, 32'hCAFE);

      // Reset during the first write, then a clean restart
      for (int i = 0; i < 4; i++) begin
         wr(16'h0700 + 16'(2 * i), 16'h0101 * 16'(i + 1));
         wr(16'h0800 + 16'(2 * i), 16'h5A5A);
      end
      src_addr = 16'h0700;
      dst_addr = 16'h0800;
      len      = 16'd4;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("t5_in_write", {31'd0, mem_write_enable}, 32'd1);
      rst = 1'b1;
      #1;
      check("t5_we_gated", {31'd0, mem_write_enable}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_req",  {31'd0, mem_req}, 32'd0);
      check("t5_addr", {16'd0, mem_address}, 32'd0);
      check("t5_nowr", {16'd0, rd(16'h0800)}, 32'h5A5A);
      run_copy(16'h0700, 16'h0800, 16'd4, 0);
      check("t5_done_cyc", done_cyc, 32'd9);
      check("t5_w0", {16'd0, rd(16'h0800)}, 32'h0101);
      check("t5_w3", {16'd0, rd(16'h0806)}, 32'h0404);

      // Overlapping forward copy replicates the first word
      wr(16'h0300, 16'hABCD);
      wr(16'h0302, 16'h1111);
      wr(16'h0304, 16'h2222);
      wr(16'h0306, 16'h3333);
      run_copy(16'h0300, 16'h0302, 16'd3, 0);
      check("t6_w0", {16'd0, rd(16'h0302)}, 32'hABCD);
      check("t6_w1", {16'd0, rd(16'h0304)}, 32'hABCD);
      check("t6_w2", {16'd0, rd(16'h0306)}, 32'hABCD);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
